// File: rtl/vvm_pkg.sv
// ---------------------------------------------------------------------------
// vvm_pkg
// Shared definitions for the VVM output path:
//   - default channel count, word width and overrun counter width
//   - serializer FSM state encoding
//   - word-counter width helper (enough bits to index 2*N_CH words)
// ---------------------------------------------------------------------------
package vvm_pkg;

  localparam int unsigned N_CH_DEF  = 32'd4;
  localparam int unsigned DW_DEF    = 32'd21;
  localparam int unsigned OVR_W_DEF = 32'd8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    GAP  = 2'd2
  } state_e;

  // Width of a counter that indexes all 2*n_ch words of a frame (never below 1).
  function automatic int unsigned wc_width(input int unsigned n_ch);
    int unsigned w;
    w = $clog2(32'd2 * n_ch);
    if (w < 32'd1) begin
      w = 32'd1;
    end else begin
      w = w;
    end
    return w;
  endfunction

endpackage

// File: rtl/iq_word_sel.sv
// ---------------------------------------------------------------------------
// iq_word_sel
// Combinational word multiplexer. Picks word sel_i out of a frame of 2*N_CH
// words of DW bits each, word k living at [(k+1)*DW-1 : k*DW]. With the I/Q
// packing used upstream this yields the order I0, Q0, I1, Q1, ...
// An index beyond the last word returns zero.
//
// Ports:
//   frame_i  in  2*N_CH*DW  packed frame
//   sel_i    in  WC_W       word index
//   word_o   out DW         selected word
// ---------------------------------------------------------------------------
module iq_word_sel
  import vvm_pkg::*;
#(
  parameter int unsigned N_CH = N_CH_DEF,
  parameter int unsigned DW   = DW_DEF,
  parameter int unsigned WC_W = wc_width(N_CH_DEF)
) (
  input  logic [2*N_CH*DW-1:0] frame_i,
  input  logic [WC_W-1:0]      sel_i,
  output logic [DW-1:0]        word_o
);

  localparam int unsigned N_WORDS = 32'd2 * N_CH;

  // Word mux with a guard against indices past the final word.
  always_comb begin
    word_o = '0;
    if (int'(sel_i) < int'(N_WORDS)) begin
      word_o = frame_i[int'(sel_i)*DW +: DW];
    end else begin
      word_o = '0;
    end
  end

endmodule

// File: rtl/iq_stream_ser.sv
// ---------------------------------------------------------------------------
// iq_stream_ser
// Turns one parallel per-channel I/Q frame into a burst of 2*N_CH words on
// stream_out/strobe_out (I0, Q0, ..., I(N-1), Q(N-1)), followed by one idle
// GAP cycle so the receiver always sees a burst boundary. A single pending
// buffer absorbs a frame that arrives mid-burst; a frame arriving while the
// pending buffer is full is dropped and counted.
//
// Ports:
//   sample_clk    in  1          clock, rising edge
//   sample_rst_n  in  1          async active-low reset
//   iq_in         in  2*N_CH*DW  parallel frame (ch k: I at word 2k, Q at 2k+1)
//   valid_in      in  1          iq_in valid this cycle
//   ovr_clr       in  1          sync clear of ovr_cnt/ovr_flag
//   stream_out    out DW         serialized word, zero when not strobed
//   strobe_out    out 1          stream_out valid
//   last_out      out 1          final word of the burst
//   busy          out 1          burst in progress or frame pending
//   ovr_cnt       out OVR_W      saturating dropped-frame count
//   ovr_flag      out 1          sticky drop indicator
// ---------------------------------------------------------------------------
module iq_stream_ser
  import vvm_pkg::*;
#(
  parameter int unsigned N_CH  = N_CH_DEF,
  parameter int unsigned DW    = DW_DEF,
  parameter int unsigned OVR_W = OVR_W_DEF
) (
  input  logic                 sample_clk,
  input  logic                 sample_rst_n,
  input  logic [2*N_CH*DW-1:0] iq_in,
  input  logic                 valid_in,
  input  logic                 ovr_clr,
  output logic [DW-1:0]        stream_out,
  output logic                 strobe_out,
  output logic                 last_out,
  output logic                 busy,
  output logic [OVR_W-1:0]     ovr_cnt,
  output logic                 ovr_flag
);

  localparam int unsigned N_WORDS = 32'd2 * N_CH;
  localparam int unsigned FW      = N_WORDS * DW;
  localparam int unsigned WC_W    = wc_width(N_CH);

  localparam logic [WC_W-1:0]  WC_LAST = WC_W'(N_WORDS - 32'd1);
  localparam logic [WC_W-1:0]  WC_ONE  = WC_W'(32'd1);
  localparam logic [OVR_W-1:0] OVR_MAX = {OVR_W{1'b1}};
  localparam logic [OVR_W-1:0] OVR_ONE = OVR_W'(32'd1);

  // Control/data state
  state_e           state_q, state_d;
  logic [WC_W-1:0]  wc_q, wc_d;
  logic [FW-1:0]    cur_q, cur_d;
  logic [FW-1:0]    pend_q, pend_d;
  logic             pend_v_q, pend_v_d;
  logic             drop_s;

  // Overrun bookkeeping
  logic [OVR_W-1:0] ovr_cnt_q, ovr_cnt_d;
  logic             ovr_flag_q, ovr_flag_d;

  // Registered outputs
  logic [DW-1:0]    stream_q, stream_d;
  logic             strobe_q, strobe_d;
  logic             last_q, last_d;
  logic             busy_q, busy_d;

  logic [DW-1:0]    next_word_s;
  logic             send_next_s;

  // The mux looks at next-cycle frame and index so the outputs can be
  // registered without adding a cycle of latency.
  iq_word_sel #(
    .N_CH (N_CH),
    .DW   (DW),
    .WC_W (WC_W)
  ) u_word_sel (
    .frame_i (cur_d),
    .sel_i   (wc_d),
    .word_o  (next_word_s)
  );

  // Next-state logic for FSM, word counter, send and pending registers.
  always_comb begin
    state_d  = state_q;
    wc_d     = wc_q;
    cur_d    = cur_q;
    pend_d   = pend_q;
    pend_v_d = pend_v_q;
    drop_s   = 1'b0;

    case (state_q)
      IDLE: begin
        if (valid_in) begin
          cur_d   = iq_in;
          wc_d    = '0;
          state_d = SEND;
        end else begin
          state_d = IDLE;
        end
      end

      SEND: begin
        if (wc_q == WC_LAST) begin
          wc_d    = '0;
          state_d = GAP;
        end else begin
          wc_d    = wc_q + WC_ONE;
          state_d = SEND;
        end
        // Mid-burst arrival: park it, or drop it if the slot is taken.
        if (valid_in) begin
          if (!pend_v_q) begin
            pend_d   = iq_in;
            pend_v_d = 1'b1;
          end else begin
            drop_s = 1'b1;
          end
        end else begin
          drop_s = 1'b0;
        end
      end

      GAP: begin
        if (pend_v_q) begin
          // The parked frame wins; a new arrival this cycle is dropped
          // because the slot is still counted as occupied.
          cur_d    = pend_q;
          pend_v_d = 1'b0;
          wc_d     = '0;
          state_d  = SEND;
          drop_s   = valid_in;
        end else if (valid_in) begin
          cur_d   = iq_in;
          wc_d    = '0;
          state_d = SEND;
        end else begin
          state_d = IDLE;
        end
      end

      default: begin
        state_d  = IDLE;
        wc_d     = '0;
        pend_v_d = 1'b0;
      end
    endcase
  end

  // Overrun counter: a drop coinciding with a clear leaves a count of one.
  always_comb begin
    ovr_cnt_d  = ovr_cnt_q;
    ovr_flag_d = ovr_flag_q;
    if (drop_s) begin
      ovr_flag_d = 1'b1;
      if (ovr_clr) begin
        ovr_cnt_d = OVR_ONE;
      end else if (ovr_cnt_q == OVR_MAX) begin
        ovr_cnt_d = OVR_MAX;
      end else begin
        ovr_cnt_d = ovr_cnt_q + OVR_ONE;
      end
    end else if (ovr_clr) begin
      ovr_cnt_d  = '0;
      ovr_flag_d = 1'b0;
    end else begin
      ovr_cnt_d  = ovr_cnt_q;
      ovr_flag_d = ovr_flag_q;
    end
  end

  // Output values for the coming cycle, derived from the next state.
  always_comb begin
    send_next_s = (state_d == SEND);
    if (send_next_s) begin
      stream_d = next_word_s;
      strobe_d = 1'b1;
      last_d   = (wc_d == WC_LAST);
    end else begin
      stream_d = '0;
      strobe_d = 1'b0;
      last_d   = 1'b0;
    end
    busy_d = (state_d != IDLE) | pend_v_d;
  end

  // State, data and output registers; reset clears everything at once.
  always_ff @(posedge sample_clk or negedge sample_rst_n) begin
    if (!sample_rst_n) begin
      state_q    <= IDLE;
      wc_q       <= '0;
      cur_q      <= '0;
      pend_q     <= '0;
      pend_v_q   <= 1'b0;
      ovr_cnt_q  <= '0;
      ovr_flag_q <= 1'b0;
      stream_q   <= '0;
      strobe_q   <= 1'b0;
      last_q     <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      wc_q       <= wc_d;
      cur_q      <= cur_d;
      pend_q     <= pend_d;
      pend_v_q   <= pend_v_d;
      ovr_cnt_q  <= ovr_cnt_d;
      ovr_flag_q <= ovr_flag_d;
      stream_q   <= stream_d;
      strobe_q   <= strobe_d;
      last_q     <= last_d;
      busy_q     <= busy_d;
    end
  end

  assign stream_out = stream_q;
  assign strobe_out = strobe_q;
  assign last_out   = last_q;
  assign busy       = busy_q;
  assign ovr_cnt    = ovr_cnt_q;
  assign ovr_flag   = ovr_flag_q;

endmodule

// File: tb/tb_iq_stream_ser.sv
// ---------------------------------------------------------------------------
// tb_iq_stream_ser
// Directed bench for iq_stream_ser with N_CH=4, DW=21, OVR_W=8.
// Frames use I_k = off+100k+1, Q_k = -(off+100k+2).
// ---------------------------------------------------------------------------
module tb_iq_stream_ser;

  localparam int N_CH  = 4;
  localparam int DW    = 21;
  localparam int OVR_W = 8;
  localparam int FW    = 2 * N_CH * DW;

  logic             clk;
  logic             rst_n;
  logic [FW-1:0]    iq_in;
  logic             valid_in;
  logic             ovr_clr;
  logic [DW-1:0]    stream_out;
  logic             strobe_out;
  logic             last_out;
  logic             busy;
  logic [OVR_W-1:0] ovr_cnt;
  logic             ovr_flag;

  int tests;
  int fails;

  iq_stream_ser #(
    .N_CH  (N_CH),
    .DW    (DW),
    .OVR_W (OVR_W)
  ) dut (
    .sample_clk   (clk),
    .sample_rst_n (rst_n),
    .iq_in        (iq_in),
    .valid_in     (valid_in),
    .ovr_clr      (ovr_clr),
    .stream_out   (stream_out),
    .strobe_out   (strobe_out),
    .last_out     (last_out),
    .busy         (busy),
    .ovr_cnt      (ovr_cnt),
    .ovr_flag     (ovr_flag)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [DW-1:0] word_of(input int off, input int w);
    int k;
    k = w / 2;
    if ((w % 2) == 0) return DW'(off + 100 * k + 1);
    else              return DW'(-(off + 100 * k + 2));
  endfunction

  function automatic logic [FW-1:0] make_frame(input int off);
    logic [FW-1:0] fr;
    fr = '0;
    for (int w = 0; w < 2 * N_CH; w++) fr[w*DW +: DW] = word_of(off, w);
    return fr;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 100; i++) begin
      if (!busy) begin
        ok = 1'b1;
        return;
      end
      step();
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; valid_in = 1'b0; ovr_clr = 1'b0; iq_in = '0;
    #12;
    tests++; if (stream_out !== '0) begin fails++; $display("FAIL reset_stream: got 0x%h exp 0", stream_out); end
    tests++; if (strobe_out !== 1'b0) begin fails++; $display("FAIL reset_strobe: got %b exp 0", strobe_out); end
    tests++; if (last_out !== 1'b0) begin fails++; $display("FAIL reset_last: got %b exp 0", last_out); end
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL reset_busy: got %b exp 0", busy); end
    tests++; if (ovr_cnt !== '0) begin fails++; $display("FAIL reset_ovr_cnt: got %0d exp 0", ovr_cnt); end
    tests++; if (ovr_flag !== 1'b0) begin fails++; $display("FAIL reset_ovr_flag: got %b exp 0", ovr_flag); end
    rst_n = 1'b1;
    step(); step();
    tests++; if (strobe_out !== 1'b0 || busy !== 1'b0) begin fails++; $display("FAIL post_reset_idle: strobe %b busy %b exp 0 0", strobe_out, busy); end
  endtask

  task automatic test_single();
    int exp_s [8] = '{1, -2, 101, -102, 201, -202, 301, -302};
    logic [DW-1:0] e;
    iq_in = make_frame(0); valid_in = 1'b1;
    step();
    valid_in = 1'b0;
    for (int w = 0; w < 8; w++) begin
      e = DW'(exp_s[w]);
      tests++; if (stream_out !== e) begin fails++; $display("FAIL single_word%0d: got 0x%h exp 0x%h", w, stream_out, e); end
      tests++; if (strobe_out !== 1'b1) begin fails++; $display("FAIL single_strobe%0d: got %b exp 1", w, strobe_out); end
      tests++; if (last_out !== (w == 7)) begin fails++; $display("FAIL single_last%0d: got %b exp %b", w, last_out, (w == 7)); end
      if (w < 7) step();
    end
    step();
    tests++; if (strobe_out !== 1'b0 || stream_out !== '0) begin fails++; $display("FAIL single_gap: strobe %b stream 0x%h exp 0 0", strobe_out, stream_out); end
    tests++; if (last_out !== 1'b0) begin fails++; $display("FAIL single_gap_last: got %b exp 0", last_out); end
    step();
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL single_busy_done: got %b exp 0", busy); end
  endtask

  task automatic test_loopback();
    logic [DW-1:0] cap_i [2];
    logic [DW-1:0] cap_q [2];
    int nb, nl;
    bit prev, qnext, ok;
    nb = 0; nl = 0; prev = 1'b0; qnext = 1'b0;
    cap_i[0] = '0; cap_i[1] = '0; cap_q[0] = '0; cap_q[1] = '0;
    for (int c = 0; c < 22; c++) begin
      if (c == 0)      begin iq_in = make_frame(1000); valid_in = 1'b1; end
      else if (c == 9) begin iq_in = make_frame(5000); valid_in = 1'b1; end
      else             valid_in = 1'b0;
      step();
      if (qnext && nb > 0 && nb <= 2) begin cap_q[nb-1] = stream_out; qnext = 1'b0; end
      if (strobe_out && !prev) begin
        if (nb < 2) cap_i[nb] = stream_out;
        nb++;
        qnext = 1'b1;
      end
      if (last_out) nl++;
      prev = strobe_out;
    end
    valid_in = 1'b0;
    tests++; if (nb != 2) begin fails++; $display("FAIL loop_bursts: got %0d exp 2", nb); end
    tests++; if (nl != 2) begin fails++; $display("FAIL loop_last_pulses: got %0d exp 2", nl); end
    tests++; if (cap_i[0] !== word_of(1000, 0)) begin fails++; $display("FAIL loop_i0_a: got 0x%h exp 0x%h", cap_i[0], word_of(1000, 0)); end
    tests++; if (cap_q[0] !== word_of(1000, 1)) begin fails++; $display("FAIL loop_q0_a: got 0x%h exp 0x%h", cap_q[0], word_of(1000, 1)); end
    tests++; if (cap_i[1] !== word_of(5000, 0)) begin fails++; $display("FAIL loop_i0_b: got 0x%h exp 0x%h", cap_i[1], word_of(5000, 0)); end
    tests++; if (cap_q[1] !== word_of(5000, 1)) begin fails++; $display("FAIL loop_q0_b: got 0x%h exp 0x%h", cap_q[1], word_of(5000, 1)); end
    tests++; if (ovr_cnt !== '0) begin fails++; $display("FAIL loop_no_drop: got %0d exp 0", ovr_cnt); end
    wait_idle(ok);
    tests++; if (!ok) begin fails++; $display("FAIL loop_idle_timeout: busy %b exp 0", busy); end
  endtask

  task automatic test_pending();
    bit ok;
    // t0: frame A; t0+4: frame B during word 3 of A.
    iq_in = make_frame(2000); valid_in = 1'b1;
    step(); valid_in = 1'b0;           // t0+1
    step(); step(); step();            // t0+4
    iq_in = make_frame(3000); valid_in = 1'b1;
    step(); valid_in = 1'b0;           // t0+5
    step(); step(); step(); step();    // t0+9 (GAP)
    tests++; if (strobe_out !== 1'b0 || busy !== 1'b1) begin fails++; $display("FAIL pend_gap: strobe %b busy %b exp 0 1", strobe_out, busy); end
    step();                            // t0+10
    for (int w = 0; w < 8; w++) begin
      tests++; if (stream_out !== word_of(3000, w) || strobe_out !== 1'b1) begin fails++; $display("FAIL pend_word%0d: got 0x%h/%b exp 0x%h/1", w, stream_out, strobe_out, word_of(3000, w)); end
      step();
    end
    tests++; if (ovr_cnt !== '0 || ovr_flag !== 1'b0) begin fails++; $display("FAIL pend_no_ovr: cnt %0d flag %b exp 0 0", ovr_cnt, ovr_flag); end
    wait_idle(ok);
    tests++; if (!ok) begin fails++; $display("FAIL pend_idle_timeout: busy %b exp 0", busy); end
  endtask

  task automatic test_overrun();
    bit ok;
    iq_in = make_frame(100); valid_in = 1'b1;        // t0
    step(); valid_in = 1'b0;                         // t0+1
    step(); iq_in = make_frame(200); valid_in = 1'b1; // t0+2
    step(); valid_in = 1'b0;                         // t0+3
    step(); iq_in = make_frame(300); valid_in = 1'b1; // t0+4
    step(); valid_in = 1'b0;                         // t0+5
    tests++; if (ovr_cnt !== 8'd1) begin fails++; $display("FAIL ovr_cnt_one: got %0d exp 1", ovr_cnt); end
    tests++; if (ovr_flag !== 1'b1) begin fails++; $display("FAIL ovr_flag_set: got %b exp 1", ovr_flag); end
    step(); step(); step(); step(); step();          // t0+10
    for (int w = 0; w < 8; w++) begin
      tests++; if (stream_out !== word_of(200, w) || strobe_out !== 1'b1) begin fails++; $display("FAIL ovr_frame2_word%0d: got 0x%h/%b exp 0x%h/1", w, stream_out, strobe_out, word_of(200, w)); end
      step();
    end
    tests++; if (strobe_out !== 1'b0) begin fails++; $display("FAIL ovr_gap: got %b exp 0", strobe_out); end
    step();
    tests++; if (strobe_out !== 1'b0 || busy !== 1'b0) begin fails++; $display("FAIL ovr_frame3_dropped: strobe %b busy %b exp 0 0", strobe_out, busy); end

    // Clear coincident with a drop: count 1 -> 2 -> (clr + drop) 1.
    iq_in = make_frame(400); valid_in = 1'b1;        // t
    step(); valid_in = 1'b0;                         // t+1
    step(); valid_in = 1'b1;                         // t+2 captured
    step();                                          // t+3 dropped
    ovr_clr = 1'b1;
    step(); valid_in = 1'b0; ovr_clr = 1'b0;         // t+4 applied clr+drop
    tests++; if (ovr_cnt !== 8'd1) begin fails++; $display("FAIL ovr_clr_with_drop: got %0d exp 1", ovr_cnt); end
    tests++; if (ovr_flag !== 1'b1) begin fails++; $display("FAIL ovr_clr_with_drop_flag: got %b exp 1", ovr_flag); end
    ovr_clr = 1'b1;
    step(); ovr_clr = 1'b0;
    tests++; if (ovr_cnt !== '0 || ovr_flag !== 1'b0) begin fails++; $display("FAIL ovr_clr_plain: cnt %0d flag %b exp 0 0", ovr_cnt, ovr_flag); end
    wait_idle(ok);
    tests++; if (!ok) begin fails++; $display("FAIL ovr_idle_timeout: busy %b exp 0", busy); end
  endtask

  task automatic test_saturation();
    bit ok;
    // Holding valid_in high drops eight of every nine frames: well over 255.
    iq_in = make_frame(700); valid_in = 1'b1;
    for (int i = 0; i < 400; i++) step();
    valid_in = 1'b0;
    step();
    tests++; if (ovr_cnt !== 8'd255) begin fails++; $display("FAIL sat_hold: got %0d exp 255", ovr_cnt); end
    tests++; if (ovr_flag !== 1'b1) begin fails++; $display("FAIL sat_flag: got %b exp 1", ovr_flag); end
    ovr_clr = 1'b1;
    step(); ovr_clr = 1'b0;
    tests++; if (ovr_cnt !== '0) begin fails++; $display("FAIL sat_clear: got %0d exp 0", ovr_cnt); end
    wait_idle(ok);
    tests++; if (!ok) begin fails++; $display("FAIL sat_idle_timeout: busy %b exp 0", busy); end
  endtask

  task automatic test_async_reset();
    iq_in = make_frame(800); valid_in = 1'b1;        // t0
    step(); valid_in = 1'b0;                         // t0+1
    step(); iq_in = make_frame(900); valid_in = 1'b1; // t0+2 pending
    step();                                          // t0+3 dropped
    step(); valid_in = 1'b0;                         // t0+4 word 3 showing
    tests++; if (stream_out !== word_of(800, 3) || ovr_cnt !== 8'd1) begin fails++; $display("FAIL arst_pre: word 0x%h cnt %0d exp 0x%h 1", stream_out, ovr_cnt, word_of(800, 3)); end
    #3 rst_n = 1'b0;
    #1;
    tests++; if (stream_out !== '0 || strobe_out !== 1'b0 || last_out !== 1'b0) begin fails++; $display("FAIL arst_outputs: stream 0x%h strobe %b last %b exp 0", stream_out, strobe_out, last_out); end
    tests++; if (busy !== 1'b0 || ovr_cnt !== '0 || ovr_flag !== 1'b0) begin fails++; $display("FAIL arst_status: busy %b cnt %0d flag %b exp 0", busy, ovr_cnt, ovr_flag); end
    #2 rst_n = 1'b1;
    step();
    tests++; if (strobe_out !== 1'b0 || busy !== 1'b0) begin fails++; $display("FAIL arst_pend_discarded: strobe %b busy %b exp 0 0", strobe_out, busy); end
    iq_in = make_frame(600); valid_in = 1'b1;
    step(); valid_in = 1'b0;
    for (int w = 0; w < 8; w++) begin
      tests++; if (stream_out !== word_of(600, w) || strobe_out !== 1'b1 || last_out !== (w == 7)) begin fails++; $display("FAIL arst_fresh_word%0d: got 0x%h/%b/%b exp 0x%h/1/%b", w, stream_out, strobe_out, last_out, word_of(600, w), (w == 7)); end
      step();
    end
    step();
    tests++; if (strobe_out !== 1'b0 || busy !== 1'b0) begin fails++; $display("FAIL arst_after_burst: strobe %b busy %b exp 0 0", strobe_out, busy); end
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    tests = 0;
    fails = 0;
    test_reset();
    test_single();
    test_loopback();
    test_pending();
    test_overrun();
    test_saturation();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
